// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: default 640x480@60 raster constants and the stream-lock state encoding.
package vid_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  typedef enum logic [1:0] {IDLE, SEEK_SOF, LOCKED} state_t;
endpackage

// File: rtl/vid_timing_counter.sv
// vid_timing_counter: cx/cy raster counters with active, sync-interval and frame-origin decode.
module vid_timing_counter import vid_timing_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [11:0] cx,
  output logic [11:0] cy,
  output logic        active,
  output logic        hs,
  output logic        vs,
  output logic        origin
);
  localparam logic [11:0] HA = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (!enable) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= (cx == HL) ? '0 : cx + 12'd1;
      if (cx == HL) cy <= (cy == VL) ? '0 : cy + 12'd1;
    end
  end
  assign active = (cx < HA) && (cy < VA);
  assign hs = (cx >= HS0) && (cx < HS1);
  assign vs = (cy >= VS0) && (cy < VS1);
  assign origin = (cx == '0) && (cy == '0);
endmodule

// File: rtl/vid_stream_timing.sv
// vid_stream_timing: raster timing generator that locks a valid/ready pixel stream to the frame
// origin and drives registered RGB/sync/de into the TMDS encoders.
module vid_stream_timing import vid_timing_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic        underflow_err,
  output logic        sof_err
);
  logic [11:0] cx, cy;
  logic active, hs, vs, origin, set_uf, set_sof;
  logic [23:0] pix;
  state_t state, nxt;
  vid_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .pixclk(pixclk), .rst_n(rst_n), .enable(enable), .cx(cx), .cy(cy),
    .active(active), .hs(hs), .vs(vs), .origin(origin)
  );
  always_comb begin
    nxt = state;
    s_ready = 1'b0;
    pix = FILL_RGB;
    set_uf = 1'b0;
    set_sof = 1'b0;
    if (!enable) nxt = IDLE;
    else case (state)
      IDLE: nxt = SEEK_SOF;
      SEEK_SOF: begin
        // stray beats are flushed; a SOF beat waits for the frame origin
        s_ready = s_valid & (~s_sof | origin);
        if (s_valid && s_sof && origin) begin
          pix = s_data;
          nxt = LOCKED;
        end
      end
      LOCKED: begin
        s_ready = active & ~(s_valid & s_sof & ~origin);
        if (active) begin
          if (!s_valid) begin
            set_uf = 1'b1;
            nxt = SEEK_SOF;
          end else if (s_sof != origin) begin
            set_sof = 1'b1;
            nxt = SEEK_SOF;
          end else pix = s_data;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {red, green, blue} <= '0;
      de <= 1'b0;
      hsync <= ~SYNC_ACTIVE_HIGH;
      vsync <= ~SYNC_ACTIVE_HIGH;
      frame_start <= 1'b0;
      underflow_err <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      state <= nxt;
      {red, green, blue} <= (enable && active) ? pix : '0;
      de <= enable & active;
      hsync <= (enable && hs) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
      vsync <= (enable && vs) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
      frame_start <= enable & origin;
      underflow_err <= set_uf | (underflow_err & ~clear_err);
      sof_err <= set_sof | (sof_err & ~clear_err);
    end
  end
  assign locked = (state == LOCKED);
endmodule
